// File: rtl/wdata_chan_mngr.sv
// Write data channel manager.
// Takes one 128-bit line with a 16-bit byte mask per request and serialises it
// into a burst of 1..4 beats of 32 bits, low word first. A one-entry pending
// buffer holds the next request while the current burst drains, so back-to-back
// bursts run with no idle cycle between them.
// All outputs come straight from flops. Each output flop is loaded from the
// next-state values, so the outputs show the same cycle timing as a decode of
// the state registers would.
module wdata_chan_mngr (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wdat_m_req,
    input  logic [127:0] wdat_m_data,
    input  logic [15:0]  wdat_m_mask,
    input  logic [1:0]   wdat_m_len,
    output logic         wdat_m_rdy,
    output logic         wvalid,
    input  logic         wready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         finish_mwd
);

    // MDEFO is the trap for illegal encodings; only reset leaves it.
    typedef enum logic [1:0] {
        MIDLE = 2'b00,
        MBUSY = 2'b01,
        MDEFO = 2'b11
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     beat_r;
    logic [1:0]     beat_nxt_s;
    logic [127:0]   act_data_r;
    logic [127:0]   act_data_nxt_s;
    logic [15:0]    act_mask_r;
    logic [15:0]    act_mask_nxt_s;
    logic [1:0]     act_len_r;
    logic [1:0]     act_len_nxt_s;
    logic [127:0]   pend_data_r;
    logic [127:0]   pend_data_nxt_s;
    logic [15:0]    pend_mask_r;
    logic [15:0]    pend_mask_nxt_s;
    logic [1:0]     pend_len_r;
    logic [1:0]     pend_len_nxt_s;
    logic           pend_valid_r;
    logic           pend_valid_nxt_s;
    logic           finish_r;
    logic           finish_nxt_s;
    logic           rdy_r;
    logic           wvalid_r;
    logic [31:0]    wdata_r;
    logic [3:0]     wstrb_r;
    logic           wlast_r;

    logic           accept_s;
    logic           hs_s;
    logic           last_s;
    logic           busy_nxt_s;
    logic [31:0]    wdata_nxt_s;
    logic [3:0]     wstrb_nxt_s;
    logic           wlast_nxt_s;
    logic           rdy_nxt_s;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        beat_nxt_s       = beat_r;
        act_data_nxt_s   = act_data_r;
        act_mask_nxt_s   = act_mask_r;
        act_len_nxt_s    = act_len_r;
        pend_data_nxt_s  = pend_data_r;
        pend_mask_nxt_s  = pend_mask_r;
        pend_len_nxt_s   = pend_len_r;
        pend_valid_nxt_s = pend_valid_r;
        finish_nxt_s     = 1'b0;

        accept_s = wdat_m_req & rdy_r;
        hs_s     = wvalid_r & wready;
        last_s   = (beat_r == act_len_r);

        case (state_r)
            MIDLE: begin
                if (accept_s) begin
                    act_data_nxt_s = wdat_m_data;
                    act_mask_nxt_s = wdat_m_mask;
                    act_len_nxt_s  = wdat_m_len;
                    beat_nxt_s     = 2'd0;
                    state_nxt_s    = MBUSY;
                end else begin
                    state_nxt_s = MIDLE;
                end
            end
            MBUSY: begin
                if (hs_s && last_s) begin
                    finish_nxt_s = 1'b1;
                    beat_nxt_s   = 2'd0;
                    if (pend_valid_r) begin
                        // Pending burst takes over with no bubble.
                        act_data_nxt_s   = pend_data_r;
                        act_mask_nxt_s   = pend_mask_r;
                        act_len_nxt_s    = pend_len_r;
                        pend_valid_nxt_s = 1'b0;
                    end else if (accept_s) begin
                        act_data_nxt_s = wdat_m_data;
                        act_mask_nxt_s = wdat_m_mask;
                        act_len_nxt_s  = wdat_m_len;
                    end else begin
                        state_nxt_s = MIDLE;
                    end
                end else begin
                    if (hs_s) begin
                        beat_nxt_s = beat_r + 2'd1;
                    end else begin
                        beat_nxt_s = beat_r;
                    end
                    if (accept_s) begin
                        pend_data_nxt_s  = wdat_m_data;
                        pend_mask_nxt_s  = wdat_m_mask;
                        pend_len_nxt_s   = wdat_m_len;
                        pend_valid_nxt_s = 1'b1;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                    end
                end
            end
            MDEFO: begin
                state_nxt_s = MDEFO;
            end
            default: begin
                state_nxt_s = MDEFO;
            end
        endcase

        busy_nxt_s = (state_nxt_s == MBUSY);
        if (busy_nxt_s) begin
            wdata_nxt_s = act_data_nxt_s[{beat_nxt_s, 5'd0} +: 32];
            wstrb_nxt_s = act_mask_nxt_s[{beat_nxt_s, 2'd0} +: 4];
            wlast_nxt_s = (beat_nxt_s == act_len_nxt_s);
        end else begin
            wdata_nxt_s = 32'd0;
            wstrb_nxt_s = 4'd0;
            wlast_nxt_s = 1'b0;
        end
        rdy_nxt_s = (state_nxt_s != MDEFO) & ~pend_valid_nxt_s;
    end

    // State, burst registers and output flops; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= MIDLE;
            beat_r       <= 2'd0;
            act_data_r   <= 128'd0;
            act_mask_r   <= 16'd0;
            act_len_r    <= 2'd0;
            pend_data_r  <= 128'd0;
            pend_mask_r  <= 16'd0;
            pend_len_r   <= 2'd0;
            pend_valid_r <= 1'b0;
            finish_r     <= 1'b0;
            rdy_r        <= 1'b1;
            wvalid_r     <= 1'b0;
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'd0;
            wlast_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            beat_r       <= beat_nxt_s;
            act_data_r   <= act_data_nxt_s;
            act_mask_r   <= act_mask_nxt_s;
            act_len_r    <= act_len_nxt_s;
            pend_data_r  <= pend_data_nxt_s;
            pend_mask_r  <= pend_mask_nxt_s;
            pend_len_r   <= pend_len_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            finish_r     <= finish_nxt_s;
            rdy_r        <= rdy_nxt_s;
            wvalid_r     <= busy_nxt_s;
            wdata_r      <= wdata_nxt_s;
            wstrb_r      <= wstrb_nxt_s;
            wlast_r      <= wlast_nxt_s;
        end
    end

    assign wdat_m_rdy = rdy_r;
    assign wvalid     = wvalid_r;
    assign wdata      = wdata_r;
    assign wstrb      = wstrb_r;
    assign wlast      = wlast_r;
    assign finish_mwd = finish_r;

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Randomised bench for wdata_chan_mngr. The reference model keeps a queue of
// expected beats plus a count of outstanding bursts. Ready, valid and the
// finish pulse are derived from those two quantities.
module tb_wdata_chan_mngr;

    logic         clk;
    logic         rst_n;
    logic         wdat_m_req;
    logic [127:0] wdat_m_data;
    logic [15:0]  wdat_m_mask;
    logic [1:0]   wdat_m_len;
    logic         wdat_m_rdy;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         finish_mwd;

    wdata_chan_mngr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wdat_m_req  (wdat_m_req),
        .wdat_m_data (wdat_m_data),
        .wdat_m_mask (wdat_m_mask),
        .wdat_m_len  (wdat_m_len),
        .wdat_m_rdy  (wdat_m_rdy),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .finish_mwd  (finish_mwd)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    bursts;
    logic  exp_fin;
    logic  model_ok;
    logic  just_reset;
    int    n_chk;
    int    n_pass;

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Random nibble mask that is sometimes zero, to exercise empty-strobe beats.
    function automatic logic [3:0] rnd_nib();
        if ($urandom_range(0, 5) == 0) return 4'h0;
        return 4'($urandom_range(0, 15));
    endfunction

    // Stimulus, checking and reference model, one clock cycle per iteration.
    initial begin
        logic       e_valid;
        logic       e_rdy;
        logic       hs;
        logic       acc;
        logic       new_req;
        logic [3:0] rdy_bias;
        beat_t      b;

        n_chk      = 0;
        n_pass     = 0;
        bursts     = 0;
        exp_fin    = 1'b0;
        model_ok   = 1'b0;
        just_reset = 1'b0;
        rst_n      = 1'b0;
        wdat_m_req = 1'b0;
        wdat_m_data = 128'd0;
        wdat_m_mask = 16'd0;
        wdat_m_len  = 2'd0;
        wready     = 1'b0;
        acc        = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            e_valid = (bursts > 0);
            e_rdy   = (bursts < 2);
            if (model_ok) begin
                chk("wdat_m_rdy", {31'd0, wdat_m_rdy}, {31'd0, e_rdy});
                chk("wvalid", {31'd0, wvalid}, {31'd0, e_valid});
                chk("finish_mwd", {31'd0, finish_mwd}, {31'd0, exp_fin});
                if (e_valid && q.size() > 0) begin
                    chk("wdata", wdata, q[0].d);
                    chk("wstrb", {28'd0, wstrb}, {28'd0, q[0].s});
                    chk("wlast", {31'd0, wlast}, {31'd0, q[0].l});
                end
                if (just_reset) begin
                    chk("rst_wdata", wdata, 32'd0);
                    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
                    chk("rst_wlast", {31'd0, wlast}, 32'd0);
                end
            end

            // Drive inputs; an unaccepted request is held unchanged.
            rst_n = (cyc < 3) ? 1'b0 : ($urandom_range(0, 249) != 0);
            rdy_bias = (cyc < 2000) ? 4'd1 : 4'd4;
            wready = ($urandom_range(0, 7) >= 32'(rdy_bias));
            if (cyc > 3000) wready = 1'b1;
            new_req = acc || !wdat_m_req;
            if (new_req) begin
                wdat_m_req  = ($urandom_range(0, 3) != 0);
                wdat_m_data = {$urandom, $urandom, $urandom, $urandom};
                wdat_m_mask = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()};
                wdat_m_len  = 2'($urandom_range(0, 3));
            end

            @(posedge clk);
            // Model update for the edge just taken.
            if (!rst_n) begin
                q.delete();
                bursts     = 0;
                exp_fin    = 1'b0;
                model_ok   = 1'b1;
                just_reset = 1'b1;
                acc        = 1'b0;
            end else begin
                just_reset = 1'b0;
                hs  = e_valid & wready;
                acc = wdat_m_req & e_rdy;
                exp_fin = 1'b0;
                if (hs && q.size() > 0) begin
                    b = q.pop_front();
                    if (b.l) begin
                        exp_fin = 1'b1;
                        bursts  = bursts - 1;
                    end
                end
                if (acc) begin
                    for (int n = 0; n <= int'(wdat_m_len); n++) begin
                        b.d = wdat_m_data[32*n +: 32];
                        b.s = wdat_m_mask[4*n +: 4];
                        b.l = (n == int'(wdat_m_len));
                        q.push_back(b);
                    end
                    bursts = bursts + 1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wdata_chan_mngr.md
Name: wdata_chan_mngr

Overview:
Write data channel manager. It is the upstream stage that drives the wvalid/wready/wdata/wstrb/wlast channel into the write data channel subordinate. It takes one 128-bit line plus a 16-bit byte mask per request and serialises it into a burst of 1–4 beats of 32 bits, low word first. A one-entry pending buffer lets the next request be held while the current burst drains, so back-to-back bursts run without a bubble.

Parameters:
none: geometry is fixed at 4 beats x 32 bits, matching the subordinate's burst counter.

Ports:
clk  in  1  clock; all logic is on posedge
rst_n  in  1  reset, synchronous, active-low
wdat_m_req  in  1  request strobe; accepted when wdat_m_rdy=1
wdat_m_data  in  128  line data; beat n = bits [32n+31:32n]
wdat_m_mask  in  16  byte strobes; beat n = bits [4n+3:4n]
wdat_m_len  in  2  number of beats minus 1 (0..3)
wdat_m_rdy  out  1  request can be accepted this cycle
wvalid  out  1  bus write-data valid
wready  in  1  bus write-data ready from the subordinate
wdata  out  32  bus write data
wstrb  out  4  bus byte strobes
wlast  out  1  final beat of the burst
finish_mwd  out  1  one-cycle pulse, registered, the cycle after the last beat handshakes

Behaviour:
- Reset (rst_n=0 at posedge): state=MIDLE, beat counter=0, active and pending registers cleared, pend_valid=0, finish_mwd=0. Therefore wvalid=0, wlast=0, wdata=0, wstrb=0, wdat_m_rdy=1. Reset mid-burst abandons the burst; no finish_mwd pulse is produced.
- State encoding: MIDLE=2'b00, MBUSY=2'b01, MDEFO=2'b11. MDEFO is the trap for illegal encodings and is left only by reset; in MDEFO wvalid=0 and wdat_m_rdy=0.
- wdat_m_rdy = ~pend_valid, outside MDEFO. It is a registered term only, with no combinational path from wready.
- Accept = wdat_m_req & wdat_m_rdy. Where an accepted request goes:
  - MIDLE: loads directly into the active registers; MBUSY is entered next cycle with beat=0. First wvalid appears 1 cycle after accept.
  - MBUSY, last beat handshaking this cycle, pend_valid=0: loads directly into active, beat=0; state stays MBUSY.
  - MBUSY otherwise: loads into pending; pend_valid=1.
- Beat output (MBUSY): wvalid=1, wdata=act_data[32*beat+:32], wstrb=act_mask[4*beat+:4], wlast=(beat==act_len).
  - All of these hold stable while wvalid & ~wready.
  - Beats with all-zero strobes are still issued.
- Handshake = wvalid & wready:
  - Non-last beat: beat increments by 1.
  - Last beat: beat returns to 0; finish_mwd=1 on the next cycle for exactly one cycle.
    - If pend_valid=1: pending moves into active, pend_valid clears, and MBUSY continues. The next cycle shows beat 0 of the new burst, so wvalid stays high with no bubble.
    - Else if a request is accepted that cycle: direct load, as in the accept rules above.
    - Else: MIDLE next cycle, wvalid=0.
- A request arriving while pending is full is not accepted; the upstream must hold it.
- wdat_m_data, wdat_m_mask and wdat_m_len are sampled only at accept; later changes are ignored.
- len=0 produces a single beat with wlast=1 on beat 0.
- Beat counter is 2 bits and never passes act_len.
- Throughput: one beat per cycle with wready held high; sustained back-to-back bursts run at 100% bus occupancy.

Test Plan:
1. Reset, then req with len=3, data=128'h44444444_33333333_22222222_11111111, mask=16'hFFFF, wready=1 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting 1 cycle after accept; wlast only on the 4th beat; finish_mwd pulses 1 cycle after it; wvalid=0 afterwards.
2. len=1, mask=16'h00F3, wready toggling 0,1,0,1 -> wdata/wstrb/wlast stay constant during stalls; wstrb=4'h3 then 4'hF; 2 handshakes total; wlast asserted with the second.
3. Burst A (len=3) active and burst B (len=0, data word0=0xCAFEBABE) accepted into pending, wready=1 -> wdat_m_rdy=0 while B is pending; B's single beat directly follows A's last beat with no wvalid gap; B carries wlast=1; finish_mwd pulses on 2 consecutive cycles.
4. Req in the same cycle A's last beat handshakes, pending empty -> direct load; next cycle is beat 0 of the new burst.
5. Assert rst_n=0 for 1 cycle at A's beat 2 -> next cycle wvalid=0, wdat_m_rdy=1, no finish_mwd; a following fresh req starts at beat 0.
